// File: rtl/apb_master.sv
// APB master: queues read/write commands in a small FIFO and issues them on APB
// as SETUP/ACCESS pairs, returning read data through a one-cycle rsp_valid pulse.
module apb_master #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int CMD_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_data,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    output logic [1:0]                 state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on current occupancy, never on a same-cycle pop.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;

    state_t          state;
    state_t          state_next;
    logic [EW-1:0]   fifo_mem [CMD_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [EW-1:0]   head;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = !rst && (count < CW'(CMD_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];

    // Command storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // Chain straight into the next SETUP so queued commands issue every 2 cycles.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (pop) begin
            {PWRITE, PADDR, PWDATA} <= head;
        end
    end

    // Read data is captured on the edge that ends ACCESS; writes leave rsp_data alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (state == ACCESS) && !PWRITE;
            if ((state == ACCESS) && !PWRITE) begin
                rsp_data <= PRDATA;
            end
        end
    end

    assign PSEL      = (state != IDLE);
    assign PENABLE   = (state == ACCESS);
    assign busy      = (state != IDLE) || !fifo_empty;
    assign state_dbg = state;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: stimulus pushes expected APB transfers and read
// responses into queues; a negedge monitor pops and compares as the bus shows them.
module tb_apb_master;

    localparam int W  = 32;
    localparam int AW = 20;
    localparam int XW = 1 + AW + W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [W-1:0]  PWDATA;
    logic [W-1:0]  PRDATA;
    logic [1:0]    state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    logic [XW-1:0] exp_q[$];
    logic [W-1:0]  exp_rsp_q[$];
    bit            saw_not_ready = 1'b0;
    int            psel_run = 0;

    logic          prev_setup;
    logic          prev_access_rd;
    logic [XW-1:0] prev_fields;
    logic [XW-1:0] mon_exp;
    logic [W-1:0]  mon_rsp;

    apb_master #(.AMBA_WORD(W), .AMBA_ADDR_WIDTH(AW), .CMD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- slave model ----------------
    function automatic logic [W-1:0] slave_rd(input logic [AW-1:0] a);
        case (a)
            20'h00004: slave_rd = 32'h12345678;
            20'h00002: slave_rd = 32'h00002222;
            20'h00010: slave_rd = 32'hA5A5A5A5;
            default:   slave_rd = {12'hC0D, a};
        endcase
    endfunction

    always_comb begin
        PRDATA = '0;
        if (PSEL && PENABLE && !PWRITE) PRDATA = slave_rd(PADDR);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_setup     = 1'b0;
            prev_access_rd = 1'b0;
            prev_fields    = '0;
        end else begin
            if (PSEL && PENABLE) begin
                check("access_after_setup", {63'b0, prev_setup}, 64'd1);
                check("access_fields_stable", {PWRITE, PADDR, PWDATA}, prev_fields);
                if (exp_q.size() == 0) begin
                    fail_now("xfer_unexpected");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("xfer", {PWRITE, PADDR, (PWRITE ? PWDATA : {W{1'b0}})}, mon_exp);
                end
            end
            if (!PSEL) begin
                check("idle_fields_hold", {PWRITE, PADDR, PWDATA}, prev_fields);
            end
            if (rsp_valid) begin
                check("rsp_after_read_access", {63'b0, prev_access_rd}, 64'd1);
                if (exp_rsp_q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    check("rsp_data", rsp_data, mon_rsp);
                end
            end
            if (cmd_valid && !cmd_ready) saw_not_ready = 1'b1;
            prev_setup     = PSEL && !PENABLE;
            prev_access_rd = PSEL && PENABLE && !PWRITE;
            prev_fields    = {PWRITE, PADDR, PWDATA};
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] rd_exp);
        int waits = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            $display("FAIL cmd_ready_timeout: got ready=0, expected ready=1");
            vectors++;
            miscompares++;
            cmd_valid = 1'b0;
        end else begin
            exp_q.push_back(w ? {1'b1, a, d} : {1'b0, a, {W{1'b0}}});
            if (!w) exp_rsp_q.push_back(rd_exp);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((busy || rsp_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            $display("FAIL drain_timeout: got busy=%0b, expected 0", busy);
            vectors++;
            miscompares++;
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen_rsp;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
        check("rst_rsp", {rsp_valid, rsp_data}, 64'd0);
        check("rst_busy_ready", {busy, cmd_ready}, 64'd0);
        check("rst_state", state_dbg, 64'd0);
        rst = 1'b0;
        #1 check("ready_after_reset", cmd_ready, 64'd1);
        @(negedge clk);

        // Single write: idle gap, SETUP, ACCESS, then idle with no response
        send(1'b1, 20'h00010, 32'hDEADBEEF, 32'h0);
        check("w_gap", {PSEL, busy}, 64'b01);
        @(negedge clk);
        check("w_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF});
        @(negedge clk);
        check("w_access", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b1, 1'b1, 20'h00010, 32'hDEADBEEF});
        @(negedge clk);
        check("w_after", {PSEL, PENABLE, rsp_valid}, 64'd0);
        wait_drain();

        // Single read: response exactly four cycles after acceptance
        send(1'b0, 20'h00004, 32'h0, 32'h12345678);
        check("r_gap", {PSEL, busy}, 64'b01);
        @(negedge clk);
        check("r_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b0, 20'h00004});
        @(negedge clk);
        check("r_access", {PSEL, PENABLE, PWRITE, PADDR, rsp_valid}, {1'b1, 1'b1, 1'b0, 20'h00004, 1'b0});
        @(negedge clk);
        check("r_rsp_n4", {rsp_valid, rsp_data}, {1'b1, 32'h12345678});
        @(negedge clk);
        check("r_rsp_one_cycle", {rsp_valid, rsp_data}, {1'b0, 32'h12345678});
        @(negedge clk);
        check("r_rsp_held", rsp_data, 32'h12345678);
        wait_drain();

        // Burst with cmd_valid held: fills the FIFO, PSEL stays high for 9 transfers
        saw_not_ready = 1'b0;
        fork
            begin
                send(1'b1, 20'h00001, 32'h11111111, 32'h0);
                send(1'b0, 20'h00002, 32'h0, 32'h00002222);
                send(1'b1, 20'h00003, 32'h33333333, 32'h0);
                send(1'b0, 20'h00004, 32'h0, 32'h12345678);
                send(1'b1, 20'h00005, 32'h55555555, 32'h0);
                send(1'b0, 20'h00006, 32'h0, 32'hC0D00006);
                send(1'b1, 20'h00007, 32'h77777777, 32'h0);
                send(1'b0, 20'h00008, 32'h0, 32'hC0D00008);
                send(1'b1, 20'h00009, 32'h99999999, 32'h0);
            end
            begin
                int t = 0;
                while (!PSEL && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                psel_run = 0;
                while (PSEL && psel_run < 60) begin
                    psel_run++;
                    @(negedge clk);
                end
            end
        join
        wait_drain();
        check("burst_psel_run", psel_run, 64'd18);
        check("burst_saw_full", {63'b0, saw_not_ready}, 64'd1);
        check("burst_queue_empty", exp_q.size() + exp_rsp_q.size(), 64'd0);

        // Reset during ACCESS of a read with two commands queued
        send(1'b0, 20'h00020, 32'h0, 32'hC0D00020);
        send(1'b1, 20'h00021, 32'h21212121, 32'h0);
        send(1'b1, 20'h00022, 32'h22222222, 32'h0);
        check("pre_rst_access", {PSEL, PENABLE, PWRITE}, 64'b110);
        #1 rst = 1'b1;
        #1 check("rst_mid_outputs", {PSEL, PENABLE, busy, cmd_ready, rsp_valid}, 64'd0);
        exp_q.delete();
        exp_rsp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_ready", cmd_ready, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", {PSEL, PENABLE, rsp_valid, busy}, 64'd0);
        end

        // Read then write: rsp_data keeps the read value through the write
        send(1'b0, 20'h00010, 32'h0, 32'hA5A5A5A5);
        send(1'b1, 20'h00018, 32'h0, 32'h0);
        seen_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen_rsp = 1'b1;
            if (seen_rsp) check("rw_rsp_hold", rsp_data, 32'hA5A5A5A5);
            @(negedge clk);
        end
        wait_drain();
        check("rw_rsp_final", rsp_data, 32'hA5A5A5A5);
        check("final_queues_empty", exp_q.size() + exp_rsp_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter AMBA_WORD, default 32, SHALL set the data width of PWDATA, PRDATA, cmd_wdata and rsp_data.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, SHALL set the width of PADDR and cmd_addr.
REQ-003 Parameter CMD_DEPTH, default 4, SHALL set the command FIFO depth; legal values are powers of 2, >= 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 cmd_valid  input  1  SHALL mark a command offered on cmd_write/cmd_addr/cmd_wdata.
REQ-008 cmd_ready  output  1  SHALL indicate the command FIFO can accept a command.
REQ-009 cmd_write  input  1  SHALL select the transfer type: 1 = write, 0 = read.
REQ-010 cmd_addr  input  AMBA_ADDR_WIDTH  SHALL carry the transfer address.
REQ-011 cmd_wdata  input  AMBA_WORD  SHALL carry write data; ignored for reads.
REQ-012 rsp_valid  output  1  SHALL pulse for one cycle when read data is returned.
REQ-013 rsp_data  output  AMBA_WORD  SHALL carry the captured read data.
REQ-014 busy  output  1  SHALL be high whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-015 PADDR, PSEL, PENABLE, PWRITE, PWDATA  outputs  AMBA_ADDR_WIDTH/1/1/1/AMBA_WORD  SHALL drive the APB bus as master.
REQ-016 PRDATA  input  AMBA_WORD  SHALL be the slave read data.

Function
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready, and pushed into the FIFO in order.
REQ-018 cmd_ready SHALL be high iff FIFO occupancy < CMD_DEPTH; it SHALL NOT account for a pop in the same cycle, so no push occurs when full.
REQ-019 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-020 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-021 IDLE: if FIFO non-empty, pop the head, register PADDR/PWRITE/PWDATA, and go to SETUP; otherwise stay in IDLE.
REQ-022 SETUP SHALL drive PSEL=1 and PENABLE=0, then go unconditionally to ACCESS (no PREADY; one-cycle access).
REQ-023 ACCESS SHALL drive PSEL=1 and PENABLE=1, with PADDR/PWRITE/PWDATA unchanged from SETUP.
REQ-024 On exit from ACCESS: if FIFO non-empty, pop, load the new command and go to SETUP (PSEL stays 1, PENABLE drops to 0); otherwise go to IDLE.
REQ-025 IDLE SHALL drive PSEL=0 and PENABLE=0; PADDR/PWRITE/PWDATA SHALL hold their last values.
REQ-026 For a read, PRDATA SHALL be sampled on the rising edge ending ACCESS into rsp_data, and rsp_valid SHALL be 1 for exactly the following cycle.
REQ-027 rsp_data SHALL hold its value until the next read capture; writes SHALL NOT assert rsp_valid or modify rsp_data.
REQ-028 Latency: a command accepted at edge N into an empty, IDLE block SHALL be in SETUP during cycle N+2, ACCESS during N+3, and rsp_valid (reads) during N+4.
REQ-029 Back-to-back queued commands SHALL issue every 2 cycles with no IDLE cycle between them.
REQ-030 Commands SHALL be issued on APB in acceptance order; none are dropped or duplicated.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, FIFO empty, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0.
REQ-032 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately and discard all queued commands, with no rsp_valid afterwards for them.

Verification
REQ-034 Single write addr 0x00010, data 0xDEADBEEF -> one SETUP then one ACCESS cycle with PWRITE=1, PADDR=0x00010, PWDATA=0xDEADBEEF; no rsp_valid.
REQ-035 Single read addr 0x00004, slave PRDATA=0x12345678 in ACCESS -> rsp_valid one cycle at N+4, rsp_data=0x12345678 held afterwards.
REQ-036 Push 4 commands (W 0x1, R 0x2, W 0x3, R 0x4) on consecutive cycles -> cmd_ready low once full, transfers in order with SETUP/ACCESS alternating and PSEL continuously high, two rsp_valid pulses.
REQ-037 FIFO full with cmd_valid held high -> no push until occupancy < 4; 5th command issued after the 4th, none lost.
REQ-038 Assert rst during ACCESS of a read with 2 commands queued -> PSEL=PENABLE=0 immediately, busy=0, no rsp_valid, bus idle after release.
REQ-039 Read PRDATA=0xA5A5A5A5, then write 0x0 -> rsp_data stays 0xA5A5A5A5 through and after the write.
